// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-group instruction link (serializer and deserializer).
package ctrl_pkg;

    localparam int ADDRW   = 8;
    localparam int OPCODEW = 2;
    localparam int SHIFT_W = OPCODEW + 2 * ADDRW;

    typedef struct packed {
        logic [OPCODEW-1:0] opcode;
        logic [ADDRW-1:0]   key;
        logic [ADDRW-1:0]   text;
    } instr_t;

    function automatic instr_t pack_instr(
        input logic [OPCODEW-1:0] opcode,
        input logic [ADDRW-1:0]   key,
        input logic [ADDRW-1:0]   text
    );
        instr_t i;
        i.opcode = opcode;
        i.key    = key;
        i.text   = text;
        return i;
    endfunction

endpackage

// File: rtl/instr_serializer.sv
// SPI mode-0 initiator: shifts {opcode, key_addr, text_addr} out MSB first, one frame per handshake.
// Handshake: a frame is accepted on the clk edge where valid_in & ready_out; ready_out is high only in IDLE.
module instr_serializer #(
    parameter int ADDRW    = ctrl_pkg::ADDRW,
    parameter int OPCODEW  = ctrl_pkg::OPCODEW,
    parameter int CLK_DIV  = 3,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [OPCODEW-1:0] opcode,
    input  logic [ADDRW-1:0]   key_addr,
    input  logic [ADDRW-1:0]   text_addr,
    input  logic               abort,
    output logic               ready_out,
    output logic               spi_clk,
    output logic               mosi,
    output logic               cs_n,
    output logic               done,
    output logic               aborted,
    output logic [2:0]         state_dbg
);

    localparam int SHIFT_W = OPCODEW + 2 * ADDRW;
    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > GAP) ? CS_HOLD : GAP;
    localparam int MAX_PH  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PH_W    = $clog2(MAX_PH + 1);
    localparam int BIT_W   = $clog2(SHIFT_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD,
        S_GAP
    } ser_state_e;

    ser_state_e         state_q;
    logic [PH_W-1:0]    phase_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               abort_q;

    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            abort_q   <= 1'b0;
            ready_out <= 1'b1;
            spi_clk   <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort only cuts a frame while cs_n is low; the GAP is always served in full.
            if (abort && (state_q inside {S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_HOLD})) begin
                state_q <= S_GAP;
                phase_q <= PH_W'(GAP - 1);
                abort_q <= 1'b1;
                cs_n    <= 1'b1;
                spi_clk <= 1'b0;
                mosi    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (valid_in) begin
                            state_q   <= S_SETUP;
                            phase_q   <= PH_W'(CS_SETUP - 1);
                            bit_cnt_q <= BIT_W'(SHIFT_W);
                            shift_q   <= {opcode, key_addr, text_addr};
                            abort_q   <= 1'b0;
                            ready_out <= 1'b0;
                            cs_n      <= 1'b0;
                            mosi      <= opcode[OPCODEW-1];
                        end
                    end
                    S_SETUP: begin
                        if (phase_q == '0) begin
                            state_q <= S_SHIFT_HI;
                            phase_q <= PH_W'(CLK_DIV - 1);
                            spi_clk <= 1'b1;
                        end else begin
                            phase_q <= phase_q - PH_W'(1);
                        end
                    end
                    S_SHIFT_HI: begin
                        if (phase_q == '0) begin
                            state_q <= S_SHIFT_LO;
                            phase_q <= PH_W'(CLK_DIV - 1);
                            spi_clk <= 1'b0;
                            shift_q <= shift_q << 1;
                            mosi    <= shift_q[SHIFT_W-2];
                            if (bit_cnt_q != '0) begin
                                bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                            end
                        end else begin
                            phase_q <= phase_q - PH_W'(1);
                        end
                    end
                    S_SHIFT_LO: begin
                        if (phase_q == '0) begin
                            if (bit_cnt_q == '0) begin
                                state_q <= S_HOLD;
                                phase_q <= PH_W'(CS_HOLD - 1);
                            end else begin
                                state_q <= S_SHIFT_HI;
                                phase_q <= PH_W'(CLK_DIV - 1);
                                spi_clk <= 1'b1;
                            end
                        end else begin
                            phase_q <= phase_q - PH_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (phase_q == '0) begin
                            state_q <= S_GAP;
                            phase_q <= PH_W'(GAP - 1);
                            cs_n    <= 1'b1;
                            mosi    <= 1'b0;
                        end else begin
                            phase_q <= phase_q - PH_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (phase_q == '0) begin
                            state_q   <= S_IDLE;
                            ready_out <= 1'b1;
                            done      <= ~abort_q;
                            aborted   <= abort_q;
                        end else begin
                            phase_q <= phase_q - PH_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_serializer.sv
// Bench for instr_serializer: timing model from the frame schedule, a bit-level receiver and directed frames.
module tb_instr_serializer;
    import ctrl_pkg::*;

    localparam int CLK_DIV   = 3;
    localparam int CS_SETUP  = 2;
    localparam int CS_HOLD   = 2;
    localparam int GAP       = 8;
    localparam int W         = SHIFT_W;
    localparam int SHIFT_END = CS_SETUP + 2 * W * CLK_DIV;
    localparam int HOLD_END  = SHIFT_END + CS_HOLD;
    localparam int PERIOD    = HOLD_END + GAP;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic               abort = 1'b0;
    logic [OPCODEW-1:0] opcode = '0;
    logic [ADDRW-1:0]   key_addr = '0;
    logic [ADDRW-1:0]   text_addr = '0;
    logic               ready_out, spi_clk, mosi, cs_n, done, aborted;
    logic [2:0]         state_dbg;

    instr_serializer #(
        .ADDRW(ADDRW), .OPCODEW(OPCODEW), .CLK_DIV(CLK_DIV),
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
        .key_addr(key_addr), .text_addr(text_addr), .abort(abort),
        .ready_out(ready_out), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n),
        .done(done), .aborted(aborted), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_log[$];
    int           acc_q[$];
    bit           m_rst = 1'b1;
    bit           m_active = 1'b0;
    int           m_acc = 0;
    int           m_abort = -1;
    logic [W-1:0] m_frame = '0;
    logic         e_cs, e_sck, e_rdy, e_done, e_abt, e_mosi;
    int           h, j;
    logic [W-1:0] rx_sh = '0;
    logic [W-1:0] want;
    int           rx_n = 0;
    int           last_rx_n = 0;
    int           hi_run = 0;
    int           last_hi_run = 0;
    int           n_done = 0, n_abt = 0, t_done = 0, t_abt = 0, t_ab = 0;
    logic         p_cs = 1'b1, p_mosi = 1'b0, p_sck = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (m_rst) begin
                if (m_active && exp_q.size() > 0) void'(exp_q.pop_back());
                m_active = 1'b0;
                m_abort  = -1;
            end
            e_done = 1'b0;
            e_abt  = 1'b0;
            if (m_active) begin
                if (m_abort >= 0 && cyc - m_abort == GAP) begin
                    m_active = 1'b0;
                    e_abt    = 1'b1;
                end else if (m_abort < 0 && cyc - m_acc == PERIOD) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end
            end
            e_cs = 1'b1; e_sck = 1'b0; e_rdy = 1'b1; e_mosi = 1'b0;
            if (m_active) begin
                e_rdy = 1'b0;
                h = cyc - m_acc;
                if (m_abort >= 0) begin
                    e_cs = 1'b1;
                end else if (h < CS_SETUP) begin
                    e_cs   = 1'b0;
                    e_mosi = m_frame[W-1];
                end else if (h < SHIFT_END) begin
                    e_cs  = 1'b0;
                    h     = h - CS_SETUP;
                    e_sck = ((h / CLK_DIV) % 2) == 0;
                    j     = (h + CLK_DIV) / (2 * CLK_DIV);
                    e_mosi = (j < W) ? m_frame[W-1-j] : 1'b0;
                end else if (h < HOLD_END) begin
                    e_cs = 1'b0;
                end
            end
            chk("cs_n", cs_n, e_cs);
            chk("spi_clk", spi_clk, e_sck);
            chk("mosi", mosi, e_mosi);
            chk("ready_out", ready_out, e_rdy);
            chk("done", done, e_done);
            chk("aborted", aborted, e_abt);
            if (spi_clk) chk("mosi_stable_hi", mosi, p_mosi);
            if (cs_n) chk("sck_idle_when_deselected", spi_clk, 1'b0);

            // receiver: sample on spi_clk rise, frame ends on cs_n rise
            if (!cs_n && spi_clk && !p_sck) begin
                rx_sh = {rx_sh[W-2:0], mosi};
                rx_n++;
            end
            if (cs_n && !p_cs) begin
                last_rx_n = rx_n;
                if (rx_n == W) begin
                    rx_log.push_back(rx_sh);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rx_unexpected: got %0h, expected no frame", rx_sh);
                    end else begin
                        want = exp_q.pop_front();
                        chk("rx_frame", rx_sh, want);
                    end
                end
            end
            if (cs_n) rx_n = 0;

            if (cs_n) hi_run++;
            else begin
                if (p_cs) last_hi_run = hi_run;
                hi_run = 0;
            end
            if (done) begin n_done++; t_done = cyc; end
            if (aborted) begin n_abt++; t_abt = cyc; end
            if (ready_out && valid_in && rst_n) acc_q.push_back(cyc + 1);
            if (abort) t_ab = cyc + 1;

            // model decision for the coming edge
            m_rst = !rst_n;
            if (rst_n) begin
                if (!m_active && valid_in) begin
                    m_active = 1'b1;
                    m_acc    = cyc + 1;
                    m_abort  = -1;
                    m_frame  = pack_instr(opcode, key_addr, text_addr);
                    exp_q.push_back(m_frame);
                end else if (m_active && m_abort < 0 && (cyc - m_acc) < HOLD_END && abort) begin
                    m_abort = cyc + 1;
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                end
            end
        end
        p_cs = cs_n; p_mosi = mosi; p_sck = spi_clk;
    end

    // driver tasks
    task automatic send_frame(input logic [1:0] op, input logic [7:0] k, input logic [7:0] t,
                              input bit keep_valid);
        bit ok;
        @(posedge clk); #1;
        valid_in = 1'b1; opcode = op; key_addr = k; text_addr = t;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (ready_out) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no ready_out, expected within 400 cycles");
        end
        @(posedge clk); #1;
        if (!keep_valid) begin
            valid_in  = 1'b0;
            opcode    = 2'($urandom_range(0, 3));
            key_addr  = 8'($urandom_range(0, 255));
            text_addr = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if (done || aborted) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL end_timeout: got no done/aborted, expected within 400 cycles");
        end
    endtask

    task automatic wait_rises(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if (rx_n >= n) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL rise_timeout: got %0d rises, expected %0d", rx_n, n);
        end
    endtask

    function automatic logic [W-1:0] rx_at(input int idx);
        if (idx >= 0 && idx < rx_log.size()) return rx_log[idx];
        return 'x;
    endfunction

    int n0, nd, na;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_out", ready_out, 1'b1);
        chk("reset_cs_n", cs_n, 1'b1);
        chk("reset_spi_clk", spi_clk, 1'b0);
        chk("reset_mosi", mosi, 1'b0);
        rst_n = 1'b1;

        // single frame A
        send_frame(2'b01, 8'hAA, 8'h55, 1'b0);
        wait_end();
        chk("a_done_latency", t_done - acc_q[$], PERIOD);
        chk("a_spi_rises", last_rx_n, W);
        chk("a_rx", rx_at(rx_log.size() - 1), 18'h1AA55);

        // back-to-back B then C with valid_in held
        n0 = rx_log.size();
        send_frame(2'b10, 8'h0F, 8'hF0, 1'b1);
        send_frame(2'b11, 8'h5A, 8'hC3, 1'b0);
        wait_end();
        chk("bc_accept_spacing", acc_q[$] - acc_q[$-1], PERIOD + 1);
        // GAP cycles plus the done cycle in which the next accept happens
        chk("bc_cs_high_run", last_hi_run, GAP + 1);
        chk("bc_rx_count", rx_log.size() - n0, 2);
        chk("b_rx", rx_at(n0), 18'h20FF0);
        chk("c_rx", rx_at(n0 + 1), 18'h35AC3);

        // abort frame B after 9 rises, then frame A
        nd = n_done; na = n_abt; n0 = rx_log.size();
        send_frame(2'b10, 8'h0F, 8'hF0, 1'b0);
        wait_rises(9);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_cs_rise", cs_n, 1'b1);
        wait_end();
        chk("abort_pulse_delay", t_abt - t_ab, GAP);
        chk("abort_pulse_count", n_abt - na, 1);
        chk("abort_no_done", n_done - nd, 0);
        chk("abort_no_rx", rx_log.size() - n0, 0);
        send_frame(2'b01, 8'hAA, 8'h55, 1'b0);
        wait_end();
        chk("after_abort_rx", rx_at(rx_log.size() - 1), 18'h1AA55);

        // valid_in pulsed while busy is ignored
        n0 = rx_log.size();
        send_frame(2'b01, 8'hAA, 8'h55, 1'b0);
        wait_rises(5);
        @(posedge clk); #1;
        valid_in = 1'b1; opcode = 2'b11; key_addr = 8'h12; text_addr = 8'h34;
        @(posedge clk); #1;
        chk("busy_ready_low", ready_out, 1'b0);
        valid_in = 1'b0;
        wait_end();
        chk("busy_rx_count", rx_log.size() - n0, 1);
        chk("busy_rx", rx_at(rx_log.size() - 1), 18'h1AA55);

        // reset mid-frame, then frame A
        nd = n_done; na = n_abt; n0 = rx_log.size();
        send_frame(2'b11, 8'h5A, 8'hC3, 1'b0);
        wait_rises(4);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_ready", ready_out, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", n_done - nd, 0);
        chk("midrst_no_aborted", n_abt - na, 0);
        send_frame(2'b01, 8'hAA, 8'h55, 1'b0);
        wait_end();
        chk("after_rst_rx_count", rx_log.size() - n0, 1);
        chk("after_rst_rx", rx_at(rx_log.size() - 1), 18'h1AA55);

        // final report
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_done", n_done, 6);
        chk("total_aborted", n_abt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
